// File: rtl/spi_master_core.sv
// SPI mode-0 master shift engine: one CS-framed full-duplex frame per accepted start strobe.
// Optional build macro SPI_LSB_FIRST_EN selects LSB-first bit order (default MSB-first).
module spi_master_core #(
    parameter int DATA_W   = 32,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go_transfer,
    input  logic [DATA_W-1:0] data_write_to_spi,
    output logic [DATA_W-1:0] data_read_from_spi,
    output logic              data_pack_ready,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int BIT_W   = $clog2(DATA_W + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int GAP_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    localparam logic [BIT_W-1:0] BIT_RELOAD   = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_RELOAD   = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] SETUP_RELOAD = GAP_W'(CS_SETUP - 1);
    localparam logic [GAP_W-1:0] HOLD_RELOAD  = GAP_W'(CS_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

`ifdef SPI_LSB_FIRST_EN
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return w[0];
    endfunction

    function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] w);
        return {1'b0, w[DATA_W-1:1]};
    endfunction

    // First sample ends up in bit 0 so a loopback frame returns the word unchanged.
    function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] w, input logic b);
        return {b, w[DATA_W-1:1]};
    endfunction
`else
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] w);
        return {w[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] w, input logic b);
        return {w[DATA_W-2:0], b};
    endfunction
`endif

    state_t            state_r, next_state_s;
    logic [DATA_W-1:0] tx_shift_r, tx_shift_nxt_s, tx_adv_s;
    logic [DATA_W-1:0] rx_shift_r, rx_shift_nxt_s;
    logic [DATA_W-1:0] data_read_r, data_read_nxt_s;
    logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic [DIV_W-1:0]  div_cnt_r, div_cnt_nxt_s;
    logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_nxt_s;
    logic              phase_r, phase_nxt_s;
    logic              sclk_r, sclk_nxt_s;
    logic              cs_n_r, cs_n_nxt_s;
    logic              mosi_r, mosi_nxt_s;
    logic              dpr_r, dpr_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              div_zero_s, gap_zero_s, bit_zero_s, last_fall_s;

    assign tx_adv_s    = tx_advance(tx_shift_r);
    assign div_zero_s  = (div_cnt_r == '0);
    assign gap_zero_s  = (gap_cnt_r == '0);
    assign bit_zero_s  = (bit_cnt_r == '0);
    // phase_r high means SCLK is in its high half; its expiry ends the bit.
    assign last_fall_s = (state_r == ST_SHIFT) && div_zero_s && phase_r && bit_zero_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:  if (go_transfer) next_state_s = ST_SETUP; else next_state_s = ST_IDLE;
            ST_SETUP: if (gap_zero_s)  next_state_s = ST_SHIFT; else next_state_s = ST_SETUP;
            ST_SHIFT: if (last_fall_s) next_state_s = ST_HOLD;  else next_state_s = ST_SHIFT;
            ST_HOLD:  if (gap_zero_s)  next_state_s = ST_IDLE;  else next_state_s = ST_HOLD;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Next values for counters, shift registers and the registered outputs.
    always_comb begin
        tx_shift_nxt_s  = tx_shift_r;
        rx_shift_nxt_s  = rx_shift_r;
        data_read_nxt_s = data_read_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        div_cnt_nxt_s   = div_cnt_r;
        gap_cnt_nxt_s   = gap_cnt_r;
        phase_nxt_s     = phase_r;
        sclk_nxt_s      = sclk_r;
        cs_n_nxt_s      = cs_n_r;
        mosi_nxt_s      = mosi_r;
        dpr_nxt_s       = dpr_r;
        busy_nxt_s      = (next_state_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (go_transfer) begin
                    tx_shift_nxt_s = data_write_to_spi;
                    rx_shift_nxt_s = '0;
                    mosi_nxt_s     = first_bit(data_write_to_spi);
                    cs_n_nxt_s     = 1'b0;
                    dpr_nxt_s      = 1'b1;
                    gap_cnt_nxt_s  = SETUP_RELOAD;
                end else begin
                    cs_n_nxt_s = 1'b1;
                end
            end
            ST_SETUP: begin
                if (gap_zero_s) begin
                    div_cnt_nxt_s = DIV_RELOAD;
                    bit_cnt_nxt_s = BIT_RELOAD;
                    phase_nxt_s   = 1'b0;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!div_zero_s) begin
                    div_cnt_nxt_s = div_cnt_r - 1'b1;
                end else if (!phase_r) begin
                    sclk_nxt_s     = 1'b1;
                    rx_shift_nxt_s = rx_insert(rx_shift_r, spi_miso);
                    phase_nxt_s    = 1'b1;
                    div_cnt_nxt_s  = DIV_RELOAD;
                end else if (bit_zero_s) begin
                    sclk_nxt_s    = 1'b0;
                    gap_cnt_nxt_s = HOLD_RELOAD;
                end else begin
                    sclk_nxt_s     = 1'b0;
                    tx_shift_nxt_s = tx_adv_s;
                    mosi_nxt_s     = first_bit(tx_adv_s);
                    bit_cnt_nxt_s  = bit_cnt_r - 1'b1;
                    phase_nxt_s    = 1'b0;
                    div_cnt_nxt_s  = DIV_RELOAD;
                end
            end
            ST_HOLD: begin
                if (gap_zero_s) begin
                    cs_n_nxt_s      = 1'b1;
                    dpr_nxt_s       = 1'b0;
                    mosi_nxt_s      = 1'b0;
                    data_read_nxt_s = rx_shift_r;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r - 1'b1;
                end
            end
            default: begin
                sclk_nxt_s = 1'b0;
                cs_n_nxt_s = 1'b1;
                dpr_nxt_s  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift_r  <= '0;
            rx_shift_r  <= '0;
            data_read_r <= '0;
            bit_cnt_r   <= '0;
            div_cnt_r   <= '0;
            gap_cnt_r   <= '0;
            phase_r     <= 1'b0;
            sclk_r      <= 1'b0;
            cs_n_r      <= 1'b1;
            mosi_r      <= 1'b0;
            dpr_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            tx_shift_r  <= tx_shift_nxt_s;
            rx_shift_r  <= rx_shift_nxt_s;
            data_read_r <= data_read_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            div_cnt_r   <= div_cnt_nxt_s;
            gap_cnt_r   <= gap_cnt_nxt_s;
            phase_r     <= phase_nxt_s;
            sclk_r      <= sclk_nxt_s;
            cs_n_r      <= cs_n_nxt_s;
            mosi_r      <= mosi_nxt_s;
            dpr_r       <= dpr_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign data_read_from_spi = data_read_r;
    assign data_pack_ready    = dpr_r;
    assign busy               = busy_r;
    assign spi_sclk           = sclk_r;
    assign spi_cs_n           = cs_n_r;
    assign spi_mosi           = mosi_r;

endmodule
